// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM bus responder.
//   state_t    : responder FSM states
//   LANE_LO/HI : byte-lane bit positions in the 2-bit write enable
//   COUNT_W    : width of the write/read transaction counters
//   LAT_W      : width of the read-latency down-counter (READ_LAT up to 15)
//   lane_mask  : forces the bytes of disabled (active-low) lanes to 0x00
package sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RD_DRIVE
  } state_t;

  localparam int LANE_LO = 0;
  localparam int LANE_HI = 1;
  localparam int COUNT_W = 16;
  localparam int LAT_W   = 4;

  function automatic logic [15:0] lane_mask(input logic [15:0] word,
                                            input logic        lb,
                                            input logic        ub);
    logic [15:0] res;
    res = word;
    if (lb) res[7:0]  = 8'h00;
    if (ub) res[15:8] = 8'h00;
    return res;
  endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Single-port 2**DEPTH_W x 16 RAM with per-byte write enable and synchronous
// read; written so synthesis maps it onto block RAM.  Contents are not reset.
//   clk   : clock
//   we    : byte write enables, bit LANE_LO = [7:0], bit LANE_HI = [15:8]
//   adr   : word address
//   wdata : write data
//   rdata : read data, registered (old data on a same-cycle write)
module sram_resp_mem
  import sram_resp_pkg::*;
#(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic [1:0]         we,
  input  logic [DEPTH_W-1:0] adr,
  input  logic [15:0]        wdata,
  output logic [15:0]        rdata
);

  logic [15:0] mem [2**DEPTH_W];

  always_ff @(posedge clk) begin
    if (we[LANE_LO]) mem[adr][7:0]  <= wdata[7:0];
    if (we[LANE_HI]) mem[adr][15:8] <= wdata[15:8];
    rdata <= mem[adr];
  end

endmodule

// File: rtl/sram_responder.sv
// Responder for the 16-bit async SRAM bus of the queue chip's memory
// controller.  Stands in for the board SRAM: decodes the active-low strobes,
// stores byte-lane writes in on-chip RAM, returns read data after READ_LAT
// cycles of stable address.  Split data bus; the tri-state is built above.
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   ram_cs/we/oe/lb/ub    : active-low bus strobes
//   adr [ADR_W]           : word address (upper bits above DEPTH_W alias)
//   dat_in [16]           : write data from the initiator
//   dat_out [16], dat_oe  : read data and drive enable
//   contention            : sticky, we and oe seen low together under cs
//   wr_count, rd_count    : committed writes / dat_oe rising edges, wrapping
//
// Optional build macro SRAM_RESP_ADDR_ECHO_EN: keeps a written-valid bitmap;
// reads of never-written words return adr[15:0] instead of RAM contents.
//
// state    | meaning
// IDLE     | bus idle, nothing driven
// WRITE    | write strobe active, latching adr/data/lanes each cycle
// RD_WAIT  | read address must stay stable for READ_LAT cycles
// RD_DRIVE | read word on dat_out, dat_oe high
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int ADR_W    = 18,
  parameter int DEPTH_W  = 10,
  parameter int READ_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ram_cs,
  input  logic               ram_we,
  input  logic               ram_oe,
  input  logic               ram_lb,
  input  logic               ram_ub,
  input  logic [ADR_W-1:0]   adr,
  input  logic [15:0]        dat_in,
  output logic [15:0]        dat_out,
  output logic               dat_oe,
  output logic               contention,
  output logic [COUNT_W-1:0] wr_count,
  output logic [COUNT_W-1:0] rd_count
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT - 1);

  logic               cs_q, we_q, oe_q, lb_q, ub_q;
  logic [ADR_W-1:0]   adr_q;
  logic [15:0]        din_q;

  state_t             state;
  logic [LAT_W-1:0]   cnt;
  logic [ADR_W-1:0]   rd_adr;
  logic [DEPTH_W-1:0] wr_adr;
  logic [15:0]        wr_dat;
  logic               wr_lb, wr_ub;

  logic               commit;
  logic [1:0]         mem_we;
  logic [DEPTH_W-1:0] mem_adr;
  logic [15:0]        mem_rdata;
  logic [15:0]        rd_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q  <= 1'b1;
      we_q  <= 1'b1;
      oe_q  <= 1'b1;
      lb_q  <= 1'b1;
      ub_q  <= 1'b1;
      adr_q <= '0;
      din_q <= '0;
    end else begin
      cs_q  <= ram_cs;
      we_q  <= ram_we;
      oe_q  <= ram_oe;
      lb_q  <= ram_lb;
      ub_q  <= ram_ub;
      adr_q <= adr;
      din_q <= dat_in;
    end
  end

  // The write lands on the WRITE exit edge; no read state can be active in
  // that cycle, so the single RAM port is shared without conflict.
  assign commit           = (state == WRITE) && (we_q || cs_q);
  assign mem_we[LANE_LO]  = commit && !wr_lb;
  assign mem_we[LANE_HI]  = commit && !wr_ub;
  assign mem_adr          = commit ? wr_adr : adr_q[DEPTH_W-1:0];

  sram_resp_mem #(.DEPTH_W(DEPTH_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .adr   (mem_adr),
    .wdata (wr_dat),
    .rdata (mem_rdata)
  );

`ifdef SRAM_RESP_ADDR_ECHO_EN
  logic [2**DEPTH_W-1:0] wr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_valid <= '0;
    else if (commit) wr_valid[wr_adr] <= 1'b1;
  end

  assign rd_word = wr_valid[rd_adr[DEPTH_W-1:0]] ? mem_rdata : 16'(rd_adr);
`else
  assign rd_word = mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      contention <= 1'b0;
    else if (!cs_q && !we_q && !oe_q) contention <= 1'b1;
  end

  // RAM is read from adr_q every cycle; when cnt reaches 0 with an unchanged
  // address, mem_rdata already holds the word at rd_adr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_adr   <= '0;
      wr_adr   <= '0;
      wr_dat   <= '0;
      wr_lb    <= 1'b1;
      wr_ub    <= 1'b1;
      dat_out  <= '0;
      dat_oe   <= 1'b0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_q && !we_q) begin
            state  <= WRITE;
            wr_adr <= adr_q[DEPTH_W-1:0];
            wr_dat <= din_q;
            wr_lb  <= lb_q;
            wr_ub  <= ub_q;
          end else if (!cs_q && !oe_q) begin
            state  <= RD_WAIT;
            cnt    <= LAT_LOAD;
            rd_adr <= adr_q;
          end
        end
        WRITE: begin
          if (we_q || cs_q) begin
            state    <= IDLE;
            wr_count <= wr_count + COUNT_W'(1);
          end else begin
            wr_adr <= adr_q[DEPTH_W-1:0];
            wr_dat <= din_q;
            wr_lb  <= lb_q;
            wr_ub  <= ub_q;
          end
        end
        RD_WAIT, RD_DRIVE: begin
          if (cs_q) begin
            state  <= IDLE;
            dat_oe <= 1'b0;
          end else if (!we_q) begin
            state  <= WRITE;
            dat_oe <= 1'b0;
            wr_adr <= adr_q[DEPTH_W-1:0];
            wr_dat <= din_q;
            wr_lb  <= lb_q;
            wr_ub  <= ub_q;
          end else if (oe_q) begin
            state  <= IDLE;
            dat_oe <= 1'b0;
          end else if (adr_q != rd_adr) begin
            state  <= RD_WAIT;
            dat_oe <= 1'b0;
            cnt    <= LAT_LOAD;
            rd_adr <= adr_q;
          end else if (state == RD_WAIT) begin
            if (cnt == '0) begin
              state    <= RD_DRIVE;
              dat_out  <= lane_mask(rd_word, lb_q, ub_q);
              dat_oe   <= 1'b1;
              rd_count <= rd_count + COUNT_W'(1);
            end else begin
              cnt <= cnt - LAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;

  localparam int ADR_W    = 18;
  localparam int DEPTH_W  = 10;
  localparam int READ_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ram_cs, ram_we, ram_oe, ram_lb, ram_ub;
  logic [ADR_W-1:0]  adr;
  logic [15:0]       dat_in;
  logic [15:0]       dat_out;
  logic              dat_oe;
  logic              contention;
  logic [15:0]       wr_count, rd_count;

  sram_responder #(.ADR_W(ADR_W), .DEPTH_W(DEPTH_W), .READ_LAT(READ_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_oe     (ram_oe),
    .ram_lb     (ram_lb),
    .ram_ub     (ram_ub),
    .adr        (adr),
    .dat_in     (dat_in),
    .dat_out    (dat_out),
    .dat_oe     (dat_oe),
    .contention (contention),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          exp_wr  = 0;
  int          exp_rd  = 0;
  logic [15:0] model [2**DEPTH_W];
  bit          mvalid [2**DEPTH_W];
  logic        prev_oe = 1'b0;
  logic [15:0] cur_exp = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dat_oe && !prev_oe) begin
        check("oe_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          cur_exp = e.data;
          check("rd_data", 32'(dat_out), 32'(e.data));
          check("rd_lat", 32'(cyc), 32'(e.cyc));
        end
      end else if (dat_oe) begin
        check("hold_data", 32'(dat_out), 32'(cur_exp));
      end
    end
    prev_oe = dat_oe;
  end

  function automatic logic [15:0] exp_read(input logic [ADR_W-1:0] a, input logic l, input logic u);
    logic [15:0] w;
    w = model[a[DEPTH_W-1:0]];
`ifdef SRAM_RESP_ADDR_ECHO_EN
    if (!mvalid[a[DEPTH_W-1:0]]) w = a[15:0];
`endif
    if (l) w[7:0]  = 8'h00;
    if (u) w[15:8] = 8'h00;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ram_cs = 1'b1; ram_we = 1'b1; ram_oe = 1'b1; ram_lb = 1'b1; ram_ub = 1'b1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    bus_idle();
    exp_wr = 0;
    exp_rd = 0;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic model_write(input logic [ADR_W-1:0] a, input logic [15:0] d,
                             input logic l, input logic u);
    if (!l) model[a[DEPTH_W-1:0]][7:0]  = d[7:0];
    if (!u) model[a[DEPTH_W-1:0]][15:8] = d[15:8];
    mvalid[a[DEPTH_W-1:0]] = 1'b1;
    exp_wr++;
  endtask

  task automatic do_write(input logic [ADR_W-1:0] a, input logic [15:0] d,
                          input logic l, input logic u, input int n);
    tick();
    ram_cs = 1'b0; ram_we = 1'b0; ram_oe = 1'b1;
    ram_lb = l; ram_ub = u; adr = a; dat_in = d;
    repeat (n) tick();
    bus_idle();
    model_write(a, d, l, u);
    repeat (3) tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    check("rd_timeout", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic do_read(input logic [ADR_W-1:0] a, input logic l, input logic u);
    exp_t e;
    tick();
    ram_cs = 1'b0; ram_we = 1'b1; ram_oe = 1'b0;
    ram_lb = l; ram_ub = u; adr = a;
    e.data = exp_read(a, l, u);
    e.cyc  = cyc + READ_LAT + 2;
    sb_q.push_back(e);
    wait_drain();
    exp_rd++;
    repeat (2) tick();
    bus_idle();
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    bus_idle();
    adr = '0;
    dat_in = '0;
    foreach (model[i]) model[i] = 16'h0;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    repeat (3) tick();
    check("rst_dat_out", 32'(dat_out), 32'h0);
    check("rst_dat_oe", 32'(dat_oe), 32'h0);
    check("rst_contention", 32'(contention), 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    check("rst_rd_count", 32'(rd_count), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic write then read
    do_write(18'h00012, 16'hBEEF, 1'b0, 1'b0, 3);
    do_read(18'h00012, 1'b0, 1'b0);
    check("wr_count_1", 32'(wr_count), 32'(exp_wr));
    check("rd_count_1", 32'(rd_count), 32'(exp_rd));

    // Byte lanes
    do_write(18'h00005, 16'h1234, 1'b0, 1'b0, 1);
    do_write(18'h00005, 16'hAB00, 1'b1, 1'b0, 2);
    do_read(18'h00005, 1'b0, 1'b0);
    do_read(18'h00005, 1'b0, 1'b1);
    check("wr_count_3", 32'(wr_count), 32'(exp_wr));

    // Read sweep with address changes every 4 cycles
    for (int i = 0; i < 6; i++)
      do_write(ADR_W'(32 + i), 16'(16'h1000 + i * 16'h0111), 1'b0, 1'b0, 1);
    tick();
    ram_cs = 1'b0; ram_we = 1'b1; ram_oe = 1'b0; ram_lb = 1'b0; ram_ub = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adr = ADR_W'(32 + i);
      e.data = exp_read(adr, 1'b0, 1'b0);
      e.cyc  = cyc + READ_LAT + 2;
      sb_q.push_back(e);
      repeat (4) tick();
    end
    wait_drain();
    exp_rd += 6;
    bus_idle();
    repeat (3) tick();
    check("rd_count_sweep", 32'(rd_count), 32'(exp_rd));

    // Contention: write wins, no drive
    tick();
    ram_cs = 1'b0; ram_we = 1'b0; ram_oe = 1'b0; ram_lb = 1'b0; ram_ub = 1'b0;
    adr = 18'h00030; dat_in = 16'hC0DE;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_oe_low", 32'(dat_oe), 32'h0);
    end
    bus_idle();
    model_write(18'h00030, 16'hC0DE, 1'b0, 1'b0);
    repeat (3) tick();
    check("contention_set", 32'(contention), 32'h1);
    check("cont_oe_after", 32'(dat_oe), 32'h0);
    do_read(18'h00030, 1'b0, 1'b0);
    check("contention_held", 32'(contention), 32'h1);

    // Aliasing of upper address bits
    do_write(18'h00007, 16'h5555, 1'b0, 1'b0, 1);
    do_read(18'h00407, 1'b0, 1'b0);
    check("wr_count_pre_rst", 32'(wr_count), 32'(exp_wr));
    check("rd_count_pre_rst", 32'(rd_count), 32'(exp_rd));

    do_reset();
    check("contention_clr", 32'(contention), 32'h0);
    check("wr_count_rst", 32'(wr_count), 32'h0);
    check("rd_count_rst", 32'(rd_count), 32'h0);

    // Reset during a write discards the pending commit
    do_write(18'h00040, 16'h1111, 1'b0, 1'b0, 1);
    tick();
    ram_cs = 1'b0; ram_we = 1'b0; ram_oe = 1'b1; ram_lb = 1'b0; ram_ub = 1'b0;
    adr = 18'h00040; dat_in = 16'h2222;
    repeat (3) tick();
    rst_n = 1'b0;
    bus_idle();
    exp_wr = 0;
    exp_rd = 0;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("wr_count_discard", 32'(wr_count), 32'h0);
    do_read(18'h00040, 1'b0, 1'b0);

`ifdef SRAM_RESP_ADDR_ECHO_EN
    do_reset();
    do_read(18'h3A5C7, 1'b0, 1'b0);
    do_write(18'h3A5C7, 16'h0001, 1'b0, 1'b0, 2);
    do_read(18'h3A5C7, 1'b0, 1'b0);
    do_reset();
    do_read(18'h3A5C7, 1'b0, 1'b0);
    do_read(18'h3A5C7, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
